// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus TX/RX handshake and status signals of spi_slave
interface spi_slave_if;
  logic       spi_SCLK;
  logic       spi_MOSI;
  logic       spi_SS_n;
  logic       spi_MISO;
  logic       spi_MISO_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       rx_overrun;
  logic       tx_underrun;
  modport slave (
    input  spi_SCLK, spi_MOSI, spi_SS_n, tx_data, tx_valid, rx_ready,
    output spi_MISO, spi_MISO_oe, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );
  modport master (
    output spi_SCLK, spi_MOSI, spi_SS_n, tx_data, tx_valid, rx_ready,
    input  spi_MISO, spi_MISO_oe, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, 1-entry TX buffer; define SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO instead of a holding register
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
  input logic        clk_clk,
  input logic        reset_reset_n,
  spi_slave_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic [SYNC_STAGES:0]   fill;
  logic       sclk_q, ss_q;
  logic [1:0] state;
  logic [7:0] tx_shift, rx_shift, tx_buf, rx_word;
  logic [2:0] bit_cnt;
  logic       tx_full, rx_push, rx_overrun_q, tx_underrun_q;
  logic       sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, ss_fall, in_shift, reload, take;
  logic       rx_valid_i, rx_full, pop, accept;
  logic [7:0] rx_data_i;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = fill[SYNC_STAGES] & ss_q & ~ss_s;
  assign in_shift  = (state == SHIFT) & ~ss_s;
  assign reload    = ((state == LOAD) & ~ss_s) | (in_shift & sclk_fall & (bit_cnt == 3'd0));
  assign take      = bus.tx_valid & ~tx_full;
  assign pop       = rx_valid_i & bus.rx_ready;
  assign accept    = rx_push & (~rx_full | pop);
  assign bus.spi_MISO_oe = state != IDLE;
  assign bus.busy        = state != IDLE;
  assign bus.spi_MISO    = (state != IDLE) & tx_shift[7];
  assign bus.tx_ready    = ~tx_full;
  assign bus.rx_valid    = rx_valid_i;
  assign bus.rx_data     = rx_data_i;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      fill      <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_SS_n};
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      sclk_q    <= sclk_s;
      ss_q      <= ss_s;
    end
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else state <= ss_s ? IDLE : (state == IDLE) ? (ss_fall ? LOAD : IDLE) : SHIFT;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rx_word  <= '0;
      bit_cnt  <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= in_shift & sclk_rise & (bit_cnt == 3'd7);
      if (ss_s || state == LOAD) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (in_shift && sclk_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (in_shift && sclk_rise && bit_cnt == 3'd7) rx_word <= {rx_shift[6:0], mosi_s};
      if (reload) tx_shift <= tx_full ? tx_buf : DUMMY_BYTE;
      else if (in_shift && sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_buf        <= '0;
      tx_full       <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      tx_underrun_q <= reload & ~tx_full;
      rx_overrun_q  <= rx_push & rx_full & ~pop;
      tx_full       <= (tx_full & ~reload) | take;
      if (take) tx_buf <= bus.tx_data;
    end
  end
`ifdef SPI_SLAVE_RX_FIFO_EN
  logic [7:0] fifo [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  assign rx_full    = count[2];
  assign rx_valid_i = |count;
  assign rx_data_i  = fifo[rd_ptr];
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fifo   <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        fifo[wr_ptr] <= rx_word;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(accept) - 3'(pop);
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_held;
  assign rx_full    = rx_held;
  assign rx_valid_i = rx_held;
  assign rx_data_i  = rx_hold;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_hold <= '0;
      rx_held <= 1'b0;
    end else begin
      if (accept) rx_hold <= rx_word;
      rx_held <= accept | (rx_held & ~pop);
    end
  end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: vector table, hand sequences and random frames against a queue-based model of spi_slave
module tb_spi_slave;
  localparam int SYNC = 2;
  localparam int H    = 8;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif
  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  spi_slave_if bus();
  spi_slave #(.SYNC_STAGES(SYNC), .DUMMY_BYTE(8'hFF)) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus(bus)
  );
  always #5 clk_clk = ~clk_clk;
  int n_tests = 0;
  int n_fail = 0;
  int under_cnt = 0;
  int over_cnt = 0;
  int tx_idx = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  logic take;
  typedef struct {
    int          len;
    logic [23:0] mosi;
    int          ntx;
    logic [23:0] tx;
    logic [23:0] exp_miso;
    int          exp_under;
  } vec_t;
  vec_t vecs[5];
  always @(negedge clk_clk)
    if (reset_reset_n) begin
      if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
      if (bus.tx_underrun) under_cnt++;
      if (bus.rx_overrun) over_cnt++;
    end
  always begin
    @(negedge clk_clk);
    take = bus.tx_valid && bus.tx_ready && reset_reset_n;
    @(posedge clk_clk);
    #1;
    if (take) tx_idx++;
    bus.tx_valid = tx_idx < tx_q.size();
    bus.tx_data  = bus.tx_valid ? tx_q[tx_idx] : 8'h00;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] got(input int i);
    return i < rx_got.size() ? 32'(rx_got[i]) : 32'hDEAD_BEEF;
  endfunction
  task automatic ss_begin();
    bus.spi_SS_n = 1'b0;
    tick(SYNC + 6);
  endtask
  task automatic ss_end();
    bus.spi_SS_n = 1'b1;
    tick(H);
    bus.spi_SCLK = 1'b0;
    tick(H);
  endtask
  task automatic spi_bits(input int nbits, input logic [39:0] mosi, output logic [39:0] miso);
    miso = '0;
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) bus.spi_SCLK = 1'b0;
      bus.spi_MOSI = mosi[8*(k/8) + 7 - k%8];
      tick(H);
      miso[8*(k/8) + 7 - k%8] = bus.spi_MISO;
      bus.spi_SCLK = 1'b1;
      tick(H);
    end
  endtask
  task automatic run_frame(input int len, input logic [39:0] mosi, input int ntx, input logic [39:0] tx,
                           output logic [39:0] miso);
    for (int i = 0; i < ntx; i++) tx_q.push_back(tx[8*i +: 8]);
    tick(4);
    ss_begin();
    spi_bits(8*len, mosi, miso);
    ss_end();
  endtask
  task automatic check_frame(input int id, input int len, input logic [39:0] mosi, input logic [39:0] miso,
                             input logic [39:0] expm, input int exp_under, input int rb, input int ub);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("frame%0d miso byte%0d", id, i), 32'(miso[8*i +: 8]), 32'(expm[8*i +: 8]));
      chk($sformatf("frame%0d rx byte%0d", id, i), got(rb + i), 32'(mosi[8*i +: 8]));
    end
    chk($sformatf("frame%0d rx pops", id), 32'(rx_got.size() - rb), 32'(len));
    chk($sformatf("frame%0d underruns", id), 32'(under_cnt - ub), 32'(exp_under));
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, " rx_data"}, 32'(bus.rx_data), 32'd0);
    chk({tag, " tx_ready"}, 32'(bus.tx_ready), 32'd1);
    chk({tag, " miso"}, 32'(bus.spi_MISO), 32'd0);
    chk({tag, " miso_oe"}, 32'(bus.spi_MISO_oe), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " rx_overrun"}, 32'(bus.rx_overrun), 32'd0);
    chk({tag, " tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
  endtask
  initial begin
    logic [39:0] miso, mosi, tx, expm;
    logic [7:0]  mq[$];
    int rb, ub, ob, len, ntx, eu;
    bus.spi_SS_n = 1'b1;
    bus.spi_SCLK = 1'b0;
    bus.spi_MOSI = 1'b0;
    bus.rx_ready = 1'b1;
    vecs[0] = '{1, 24'h00003C, 1, 24'h0000A5, 24'h0000A5, 0};
    vecs[1] = '{1, 24'h000000, 0, 24'h000000, 24'h0000FF, 1};
    vecs[2] = '{3, 24'h332211, 3, 24'h030201, 24'h030201, 0};
    vecs[3] = '{2, 24'h00C35A, 1, 24'h000077, 24'h00FF77, 1};
    vecs[4] = '{1, 24'h0000FF, 1, 24'h000000, 24'h000000, 0};
    tick(3);
    chk_reset_outputs("reset");
    reset_reset_n = 1'b1;
    tick(SYNC + 4);
    chk("idle busy", 32'(bus.busy), 32'd0);
    for (int v = 0; v < 5; v++) begin
      rb = rx_got.size();
      ub = under_cnt;
      run_frame(vecs[v].len, {16'h0, vecs[v].mosi}, vecs[v].ntx, {16'h0, vecs[v].tx}, miso);
      check_frame(v, vecs[v].len, {16'h0, vecs[v].mosi}, miso, {16'h0, vecs[v].exp_miso}, vecs[v].exp_under, rb, ub);
    end
    for (int r = 0; r < 20; r++) begin
      len  = int'($urandom_range(1, 3));
      ntx  = int'($urandom_range(0, len));
      mosi = {16'h0, 24'($urandom)};
      tx   = {16'h0, 24'($urandom)};
      mq   = {};
      for (int i = 0; i < ntx; i++) mq.push_back(tx[8*i +: 8]);
      expm = '0;
      eu   = 0;
      for (int i = 0; i < len; i++)
        if (mq.size() > 0) expm[8*i +: 8] = mq.pop_front();
        else begin
          expm[8*i +: 8] = 8'hFF;
          eu++;
        end
      rb = rx_got.size();
      ub = under_cnt;
      run_frame(len, mosi, ntx, tx, miso);
      check_frame(100 + r, len, mosi, miso, expm, eu, rb, ub);
    end
    bus.rx_ready = 1'b0;
    mosi = 40'hF0_18_24_42_81;
    rb = rx_got.size();
    ob = over_cnt;
    ss_begin();
    spi_bits(8*(RX_CAP + 1), mosi, miso);
    ss_end();
    chk("overrun pulses", 32'(over_cnt - ob), 32'd1);
    chk("overrun rx_valid held", 32'(bus.rx_valid), 32'd1);
    chk("overrun rx_data held", 32'(bus.rx_data), 32'h81);
    chk("overrun no pops", 32'(rx_got.size() - rb), 32'd0);
    bus.rx_ready = 1'b1;
    tick(RX_CAP + 3);
    chk("overrun drained count", 32'(rx_got.size() - rb), 32'(RX_CAP));
    for (int i = 0; i < RX_CAP; i++) chk($sformatf("overrun kept byte%0d", i), got(rb + i), 32'(mosi[8*i +: 8]));
    chk("overrun drained rx_valid", 32'(bus.rx_valid), 32'd0);
    rb = rx_got.size();
    ss_begin();
    spi_bits(5, 40'h55, miso);
    ss_end();
    chk("partial no delivery", 32'(rx_got.size() - rb), 32'd0);
    run_frame(1, 40'h7E, 0, 40'h0, miso);
    chk("after partial pops", 32'(rx_got.size() - rb), 32'd1);
    chk("after partial rx", got(rb), 32'h7E);
    bus.rx_ready = 1'b0;
    run_frame(1, 40'h96, 1, 40'h5C, miso);
    chk("pre-reset miso", 32'(miso[7:0]), 32'h5C);
    chk("pre-reset rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("pre-reset rx_data", 32'(bus.rx_data), 32'h96);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    tick(4);
    ss_begin();
    spi_bits(4, 40'hF3, miso);
    chk("mid-frame miso nibble", 32'(miso[7:4]), 32'hA);
    chk("mid-frame busy", 32'(bus.busy), 32'd1);
    chk("mid-frame tx_ready", 32'(bus.tx_ready), 32'd0);
    reset_reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid-frame reset");
    tick(2);
    reset_reset_n = 1'b1;
    tick(20);
    chk("post-reset ss low busy", 32'(bus.busy), 32'd0);
    chk("post-reset ss low oe", 32'(bus.spi_MISO_oe), 32'd0);
    bus.spi_SCLK = 1'b0;
    ss_end();
    bus.rx_ready = 1'b1;
    rb = rx_got.size();
    ub = under_cnt;
    run_frame(1, 40'hC7, 1, 40'h3E, miso);
    check_frame(200, 1, 40'hC7, miso, 40'h3E, 0, rb, ub);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
